// File: rtl/fast_serial_peer_pkg.sv
// Shared types and constants for the fast-serial peer (CIA SP/CNT link partner).
package fast_serial_peer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RX      = 2'd1,
    ST_TX_LOW  = 2'd2,
    ST_TX_HIGH = 2'd3
  } state_e;

  localparam int   BYTE_BITS     = 8;
  localparam logic LINE_RELEASED = 1'b1;

endpackage

// File: rtl/fast_serial_sync.sv
// Bus-line synchroniser: two free-running clk stages, then one ce-gated stage.
// With EDGE_OUT=1 the output is a rising-edge flag that holds for one ce tick;
// with EDGE_OUT=0 the output is the ce-gated level itself.
module fast_serial_sync
  import fast_serial_peer_pkg::*;
#(
  parameter bit EDGE_OUT = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic ce_i,
  input  logic line_i,
  output logic out_o
);

  logic meta_q;
  logic sync_q;
  logic stage_q;

  // Metastability stages run every clk; the sampling stage advances only on ce.
  // Reset to the released level so an idle bus never shows a false edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q  <= LINE_RELEASED;
      sync_q  <= LINE_RELEASED;
      stage_q <= LINE_RELEASED;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      if (ce_i) begin
        stage_q <= sync_q;
      end
    end
  end

  generate
    if (EDGE_OUT) begin : g_edge
      logic prev_q;

      // Previous sampled level, advanced on the same ce tick as the sampling stage.
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          prev_q <= LINE_RELEASED;
        end else if (ce_i) begin
          prev_q <= stage_q;
        end
      end

      assign out_o = stage_q & ~prev_q;
    end else begin : g_level
      assign out_o = stage_q;
    end
  endgenerate

endmodule

// File: rtl/fast_serial_peer.sv
// Far-end peer for the CIA serial port: receives bytes clocked by the CIA's CNT,
// and transmits bytes by generating CNT itself. Half-duplex, open-collector drives.
//
// state      | meaning
// ST_IDLE    | lines released, waiting for a CNT edge (rx) or a host byte (tx)
// ST_RX      | shifting in SP on each CNT rising edge, timeout armed
// ST_TX_LOW  | driving CNT low with the current bit on SP
// ST_TX_HIGH | CNT released high; the CIA samples SP on this rising edge
module fast_serial_peer
  import fast_serial_peer_pkg::*;
#(
  parameter int HALF_PERIOD = 4,
  parameter int RX_TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       sp_in,
  input  logic       cnt_in,
  output logic       sp_out,
  output logic       cnt_out,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       rx_abort,
  output logic       busy
);

  localparam logic [7:0] HALF_RELOAD = 8'(HALF_PERIOD - 1);
  localparam logic [7:0] RX_RELOAD   = 8'(RX_TIMEOUT - 1);
  localparam logic [2:0] LAST_BIT    = 3'(BYTE_BITS - 1);

  state_e     state_q;
  logic [7:0] shreg_q;
  logic [2:0] bitcnt_q;
  logic [7:0] timer_q;
  logic       sp_out_q;
  logic       cnt_out_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       rx_overrun_q;
  logic       rx_abort_q;

  logic       cnt_rise;
  logic       sp_level;
  logic [7:0] rx_shift_d;
  logic       rx_done;

  fast_serial_sync #(.EDGE_OUT(1'b1)) u_cnt_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .ce_i    (ce),
    .line_i  (cnt_in),
    .out_o   (cnt_rise)
  );

  fast_serial_sync #(.EDGE_OUT(1'b0)) u_sp_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .ce_i    (ce),
    .line_i  (sp_in),
    .out_o   (sp_level)
  );

  assign rx_shift_d = {shreg_q[6:0], sp_level};
  assign rx_done    = ce && (state_q == ST_RX) && cnt_rise && (bitcnt_q == LAST_BIT);

  // An incoming CNT edge in IDLE pre-empts the host byte, so ready drops with it.
  assign tx_ready   = (state_q == ST_IDLE) && !cnt_rise && !reset;
  assign busy       = (state_q != ST_IDLE);

  assign sp_out     = sp_out_q;
  assign cnt_out    = cnt_out_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_overrun_q;
  assign rx_abort   = rx_abort_q;

  // Link state machine with registered line drives and receive status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shreg_q      <= 8'h00;
      bitcnt_q     <= 3'd0;
      timer_q      <= 8'h00;
      sp_out_q     <= LINE_RELEASED;
      cnt_out_q    <= LINE_RELEASED;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      rx_abort_q   <= 1'b0;
    end else begin
      rx_abort_q <= 1'b0;

      // Host acknowledge is honoured every clk; a completing byte beats it.
      if (rx_done) begin
        rx_data_q    <= rx_shift_d;
        rx_valid_q   <= 1'b1;
        rx_overrun_q <= (rx_overrun_q | rx_valid_q) & ~rx_ack;
      end else if (rx_ack) begin
        rx_valid_q   <= 1'b0;
        rx_overrun_q <= 1'b0;
      end

      if (ce) begin
        case (state_q)
          ST_IDLE: begin
            if (cnt_rise) begin
              shreg_q  <= rx_shift_d;
              bitcnt_q <= 3'd1;
              timer_q  <= RX_RELOAD;
              state_q  <= ST_RX;
            end else if (tx_valid && tx_ready) begin
              shreg_q   <= tx_data;
              bitcnt_q  <= 3'd0;
              timer_q   <= HALF_RELOAD;
              cnt_out_q <= 1'b0;
              sp_out_q  <= tx_data[7];
              state_q   <= ST_TX_LOW;
            end
          end

          ST_RX: begin
            if (cnt_rise) begin
              shreg_q <= rx_shift_d;
              timer_q <= RX_RELOAD;
              if (bitcnt_q == LAST_BIT) begin
                bitcnt_q <= 3'd0;
                state_q  <= ST_IDLE;
              end else begin
                bitcnt_q <= bitcnt_q + 3'd1;
              end
            end else if (timer_q == 8'h00) begin
              rx_abort_q <= 1'b1;
              shreg_q    <= 8'h00;
              bitcnt_q   <= 3'd0;
              state_q    <= ST_IDLE;
            end else begin
              timer_q <= timer_q - 8'd1;
            end
          end

          ST_TX_LOW: begin
            if (timer_q == 8'h00) begin
              cnt_out_q <= LINE_RELEASED;
              timer_q   <= HALF_RELOAD;
              state_q   <= ST_TX_HIGH;
            end else begin
              timer_q <= timer_q - 8'd1;
            end
          end

          ST_TX_HIGH: begin
            if (timer_q == 8'h00) begin
              shreg_q <= {shreg_q[6:0], 1'b0};
              if (bitcnt_q == LAST_BIT) begin
                sp_out_q <= LINE_RELEASED;
                bitcnt_q <= 3'd0;
                state_q  <= ST_IDLE;
              end else begin
                bitcnt_q  <= bitcnt_q + 3'd1;
                cnt_out_q <= 1'b0;
                sp_out_q  <= shreg_q[6];
                timer_q   <= HALF_RELOAD;
                state_q   <= ST_TX_LOW;
              end
            end else begin
              timer_q <= timer_q - 8'd1;
            end
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fast_serial_peer.sv
// Bench for fast_serial_peer: acts as the CIA end of the SP/CNT link.
module tb_fast_serial_peer;

  localparam int HP  = 4;
  localparam int RXT = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ce = 1'b1;
  logic       tb_sp = 1'b1;
  logic       tb_cnt = 1'b1;
  logic       sp_in, cnt_in, sp_out, cnt_out;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       rx_overrun, rx_abort, busy;

  // Wired-AND bus: either end can pull a line low.
  assign sp_in  = sp_out & tb_sp;
  assign cnt_in = cnt_out & tb_cnt;

  fast_serial_peer #(.HALF_PERIOD(HP), .RX_TIMEOUT(RXT)) dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .sp_in      (sp_in),
    .cnt_in     (cnt_in),
    .sp_out     (sp_out),
    .cnt_out    (cnt_out),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .rx_overrun (rx_overrun),
    .rx_abort   (rx_abort),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CIA-side sampler: SP is captured on every rising CNT driven by the peer.
  logic       cnt_prev = 1'b1;
  logic [7:0] mon_sh = 8'h00;
  int         mon_bits = 0;
  always @(negedge clk) begin
    if (reset) begin
      mon_bits = 0;
      cnt_prev = 1'b1;
      tx_exp_q.delete();
    end else begin
      if (cnt_out && !cnt_prev) begin
        mon_sh = {mon_sh[6:0], sp_out};
        mon_bits++;
        if (mon_bits == 8) begin
          mon_bits = 0;
          check_eq("tx_pending", 32'(tx_exp_q.size() > 0), 1);
          if (tx_exp_q.size() > 0) check_eq("tx_byte", mon_sh, tx_exp_q.pop_front());
        end
      end
      cnt_prev = cnt_out;
    end
  end

  // Drive bits first..last of b as CNT low/high pulses, SP set during the low phase.
  task automatic rx_bits(input logic [7:0] b, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      tb_cnt = 1'b0;
      tb_sp  = b[7-i];
      repeat (HP) @(negedge clk);
      tb_cnt = 1'b1;
      repeat (HP) @(negedge clk);
    end
    tb_sp = 1'b1;
  endtask

  task automatic rx_expect();
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (!rx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("rx_valid", rx_valid, 1);
    if (rx_exp_q.size() > 0) check_eq("rx_data", rx_data, rx_exp_q.pop_front());
  endtask

  task automatic rx_send(input logic [7:0] b);
    rx_exp_q.push_back(b);
    rx_bits(b, 0, 7);
    rx_expect();
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    int cycles, lows, n, aborts, first;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_ready", tx_ready, 0);
    check_eq("rst_sp_out", sp_out, 1);
    check_eq("rst_cnt_out", cnt_out, 1);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_rx_data", rx_data, 8'h00);
    check_eq("rst_overrun", rx_overrun, 0);
    check_eq("rst_abort", rx_abort, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rel_tx_ready", tx_ready, 1);

    // ce low: a pending byte must not be taken.
    ce = 1'b0;
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("ce_hold_busy", busy, 0);
    check_eq("ce_hold_cnt", cnt_out, 1);

    // Transmit A5.
    tx_exp_q.push_back(8'hA5);
    ce = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    check_eq("tx_start_busy", busy, 1);
    check_eq("tx_start_sp", sp_out, 1);
    cycles = 0;
    lows = 0;
    do begin
      if (!cnt_out) lows++;
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end while (!tx_ready && cycles < 200);
    check_eq("tx_byte_time", cycles, 16 * HP);
    check_eq("tx_cnt_low_ticks", lows, 8 * HP);
    check_eq("tx_end_sp", sp_out, 1);
    check_eq("tx_end_cnt", cnt_out, 1);
    check_eq("tx_end_busy", busy, 0);
    check_eq("tx_drained", tx_exp_q.size(), 0);

    // Receive 3C and acknowledge.
    rx_send(8'h3C);
    check_eq("rx_no_overrun", rx_overrun, 0);
    ack_pulse();
    check_eq("rx_ack_valid", rx_valid, 0);

    // Overrun: two bytes without an ack.
    rx_send(8'h11);
    check_eq("ovr_first_flag", rx_overrun, 0);
    rx_send(8'h22);
    check_eq("ovr_flag", rx_overrun, 1);
    ack_pulse();
    check_eq("ovr_ack_valid", rx_valid, 0);
    check_eq("ovr_ack_flag", rx_overrun, 0);

    // Timeout: three pulses, then silence.
    rx_bits(8'hFF, 0, 1);
    tb_cnt = 1'b0;
    tb_sp = 1'b0;
    repeat (HP) @(negedge clk);
    tb_cnt = 1'b1;
    tb_sp = 1'b1;
    n = 0;
    aborts = 0;
    first = -1;
    repeat (100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (rx_abort) begin
        aborts++;
        if (first < 0) first = n;
      end
    end
    check_eq("to_abort_count", aborts, 1);
    check_eq("to_abort_time", first, 3 + 1 + RXT);
    check_eq("to_rx_valid", rx_valid, 0);
    check_eq("to_busy", busy, 0);
    rx_send(8'h81);
    ack_pulse();

    // Collision: tx_valid raised in the tick the CNT edge is seen.
    tx_exp_q.push_back(8'h96);
    rx_exp_q.push_back(8'hC3);
    tx_data = 8'h96;
    tb_cnt = 1'b0;
    tb_sp = 1'b1;
    repeat (HP) @(negedge clk);
    tb_cnt = 1'b1;
    repeat (3) @(negedge clk);
    tx_valid = 1'b1;
    check_eq("col_ready_drop", tx_ready, 0);
    @(negedge clk);
    check_eq("col_rx_busy", busy, 1);
    check_eq("col_cnt_released", cnt_out, 1);
    rx_bits(8'hC3, 1, 7);
    rx_expect();
    n = 0;
    while (cnt_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("col_tx_started", cnt_out, 0);
    tx_valid = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("col_tx_done", busy, 0);
    check_eq("col_tx_drained", tx_exp_q.size(), 0);
    ack_pulse();

    // Reset during the low phase of the fourth bit of E1 (bit value 0).
    tx_data = 8'hE1;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (25) @(negedge clk);
    check_eq("rst_tx_cnt_low", cnt_out, 0);
    check_eq("rst_tx_sp_low", sp_out, 0);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_tx_cnt_rel", cnt_out, 1);
    check_eq("rst_tx_sp_rel", sp_out, 1);
    check_eq("rst_tx_ready_low", tx_ready, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_tx_busy", busy, 0);
    check_eq("rst_tx_ready", tx_ready, 1);
    repeat (10) @(negedge clk);
    check_eq("end_cnt_idle", cnt_out, 1);
    check_eq("end_rx_queue", rx_exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
